// File: rtl/y_pair_fetch.sv
// Fetches one Y-matrix operand pair per distinct decoder address pair and presents it on a valid/ready port.
// Optional address-pair consistency check enabled by defining YPF_PAIR_CHECK_EN.
module y_pair_fetch #(
   localparam int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32,
   parameter logic [ADDR_W-1:0] NULL_ADDR = 11'h7FF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] yPF_inAddr1,
   input  logic [ADDR_W-1:0] yPF_inAddr2,
   output logic              sram_readEn,
   output logic [ADDR_W-1:0] sram_readAddr,
   input  logic [DATA_W-1:0] sram_readData,
   output logic [DATA_W-1:0] yPF_outData1,
   output logic [DATA_W-1:0] yPF_outData2,
   output logic              yPF_outValid,
   input  logic              yPF_outReady,
   output logic              yPF_err
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD1  = 3'd1;
   localparam logic [2:0] RD2  = 3'd2;
   localparam logic [2:0] WAIT = 3'd3;
   localparam logic [2:0] HOLD = 3'd4;

   logic [2:0]        state, state_n;
   logic [ADDR_W-1:0] last_addr1, last_addr1_n;
   logic [ADDR_W-1:0] lat_addr1, lat_addr1_n;
   logic [ADDR_W-1:0] lat_addr2, lat_addr2_n;
   logic              read_en_n;
   logic [ADDR_W-1:0] read_addr_n;
   logic [DATA_W-1:0] out_data1_n, out_data2_n;
   logic              out_valid_n;
   logic              new_req;

   // A held decoder pair must not be refetched; only a change or a NULL gap re-arms it
   assign new_req = (yPF_inAddr1 != NULL_ADDR) && (yPF_inAddr1 != last_addr1);

   // Next-state and next-output logic
   always_comb begin
      state_n      = state;
      last_addr1_n = last_addr1;
      lat_addr1_n  = lat_addr1;
      lat_addr2_n  = lat_addr2;
      read_en_n    = sram_readEn;
      read_addr_n  = sram_readAddr;
      out_data1_n  = yPF_outData1;
      out_data2_n  = yPF_outData2;
      out_valid_n  = yPF_outValid;
      case (state)
         IDLE: begin
            if (new_req) begin
               lat_addr1_n  = yPF_inAddr1;
               lat_addr2_n  = yPF_inAddr2;
               last_addr1_n = yPF_inAddr1;
               read_en_n    = 1'b1;
               read_addr_n  = yPF_inAddr1;
               state_n      = RD1;
            end else if (yPF_inAddr1 == NULL_ADDR) begin
               last_addr1_n = NULL_ADDR;
            end
         end
         RD1: begin
            if (lat_addr2 != NULL_ADDR) begin
               read_en_n   = 1'b1;
               read_addr_n = lat_addr2;
            end else begin
               read_en_n   = 1'b0;
               read_addr_n = NULL_ADDR;
            end
            state_n = RD2;
         end
         RD2: begin
            out_data1_n = sram_readData;
            read_en_n   = 1'b0;
            read_addr_n = NULL_ADDR;
            state_n     = WAIT;
         end
         WAIT: begin
            out_data2_n = (lat_addr2 != NULL_ADDR) ? sram_readData : '0;
            out_valid_n = 1'b1;
            state_n     = HOLD;
         end
         HOLD: begin
            if (yPF_outValid && yPF_outReady) begin
               out_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         last_addr1    <= NULL_ADDR;
         lat_addr1     <= NULL_ADDR;
         lat_addr2     <= NULL_ADDR;
         sram_readEn   <= 1'b0;
         sram_readAddr <= NULL_ADDR;
         yPF_outData1  <= '0;
         yPF_outData2  <= '0;
         yPF_outValid  <= 1'b0;
      end else begin
         state         <= state_n;
         last_addr1    <= last_addr1_n;
         lat_addr1     <= lat_addr1_n;
         lat_addr2     <= lat_addr2_n;
         sram_readEn   <= read_en_n;
         sram_readAddr <= read_addr_n;
         yPF_outData1  <= out_data1_n;
         yPF_outData2  <= out_data2_n;
         yPF_outValid  <= out_valid_n;
      end
   end

`ifdef YPF_PAIR_CHECK_EN
   logic pair_bad;
   logic err_n;

   // addr2 must be NULL or addr1+1 with 11-bit wrap
   assign pair_bad = (yPF_inAddr2 != NULL_ADDR) &&
                     (yPF_inAddr2 != ADDR_W'(yPF_inAddr1 + ADDR_W'(1)));

   always_comb begin
      err_n = yPF_err;
      if ((state == IDLE) && new_req && pair_bad) begin
         err_n = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         yPF_err <= 1'b0;
      end else begin
         yPF_err <= err_n;
      end
   end
`else
   assign yPF_err = 1'b0;
`endif

endmodule
